// File: rtl/ris_pkg.sv
// Shared opcode constants, command word layout and serialiser state encoding for the RIS frame decoder.
package ris_pkg;

   localparam logic [7:0] OP_WRITE = 8'h01;
   localparam logic [7:0] OP_APPLY = 8'h02;
   localparam logic [7:0] OP_CLEAR = 8'h03;

   // Byte 0 of the received word lands in the low byte.
   typedef struct packed {
      logic [7:0] value;
      logic [7:0] addr;
      logic [7:0] opcode;
   } cmd_t;

   typedef enum logic [1:0] {
      SER_IDLE  = 2'd0,
      SER_LOAD  = 2'd1,
      SER_SHIFT = 2'd2,
      SER_LATCH = 2'd3
   } ser_state_t;

endpackage

// File: rtl/ris_serializer.sv
// Shifts a parallel snapshot MSB first onto a clock/data/latch chain; start is honoured only in IDLE.
// Latency: LOAD one cycle after start, first sclk rise SCLK_DIV cycles later; no backpressure.
module ris_serializer
   import ris_pkg::*;
#(
   parameter int NB       = 32,
   parameter int SCLK_DIV = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [NB-1:0] snapshot,
   output logic          busy,
   output logic          ris_sclk,
   output logic          ris_sdo,
   output logic          ris_latch
);

   localparam int DW = $clog2(2 * SCLK_DIV) + 1;
   localparam int BW = $clog2(NB) + 1;
   localparam logic [DW-1:0] DIV_HALF = DW'(SCLK_DIV - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(2 * SCLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(NB - 1);

   ser_state_t    state_q;
   logic [DW-1:0] div_q;
   logic [BW-1:0] bit_q;
   logic [NB-1:0] shreg_q;
   logic          busy_q;
   logic          sclk_q;
   logic          sdo_q;
   logic          latch_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SER_IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         busy_q  <= 1'b0;
         sclk_q  <= 1'b0;
         sdo_q   <= 1'b0;
         latch_q <= 1'b0;
      end else begin
         case (state_q)
            SER_IDLE: begin
               if (start) begin
                  state_q <= SER_LOAD;
                  busy_q  <= 1'b1;
               end
            end
            SER_LOAD: begin
               shreg_q <= snapshot;
               sdo_q   <= snapshot[NB-1];
               sclk_q  <= 1'b0;
               div_q   <= '0;
               bit_q   <= '0;
               state_q <= SER_SHIFT;
            end
            SER_SHIFT: begin
               if (div_q == DIV_LAST) begin
                  div_q  <= '0;
                  sclk_q <= 1'b0;
                  if (bit_q == BIT_LAST) begin
                     state_q <= SER_LATCH;
                     sdo_q   <= 1'b0;
                     latch_q <= 1'b1;
                  end else begin
                     bit_q   <= bit_q + BW'(1);
                     shreg_q <= shreg_q << 1;
                     sdo_q   <= shreg_q[NB-2];
                  end
               end else begin
                  // sclk rises once the low half-period has elapsed
                  div_q  <= div_q + DW'(1);
                  sclk_q <= (div_q >= DIV_HALF);
               end
            end
            SER_LATCH: begin
               if (div_q == DIV_HALF) begin
                  div_q   <= '0;
                  latch_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= SER_IDLE;
               end else begin
                  div_q <= div_q + DW'(1);
               end
            end
            default: state_q <= SER_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign ris_sclk  = sclk_q;
   assign ris_sdo   = sdo_q;
   assign ris_latch = latch_q;

endmodule

// File: rtl/ris_frame_decoder.sv
// Decodes UART command words into a shadow phase bank, counts rejects, and triggers the serialiser on APPLY.
// Latency: command effects land on the strobe edge; no backpressure, APPLY while busy is rejected.
module ris_frame_decoder
   import ris_pkg::*;
#(
   parameter int N_ELEM     = 16,
   parameter int PHASE_BITS = 2,
   parameter int W_IN       = 24,
   parameter int SCLK_DIV   = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            s_valid,
   input  logic [W_IN-1:0] s_data,
   output logic            ris_sclk,
   output logic            ris_sdo,
   output logic            ris_latch,
   output logic            busy,
   output logic            cmd_err,
   output logic [7:0]      err_count
);

   localparam int NB = N_ELEM * PHASE_BITS;

   cmd_t                  cmd;
   logic                  write_ok;
   logic                  apply_ok;
   logic                  clear_cmd;
   logic                  reject;
   logic                  ser_busy;
   logic [NB-1:0]         snapshot;
   logic [PHASE_BITS-1:0] shadow_q [N_ELEM];
   logic [PHASE_BITS-1:0] shadow_d [N_ELEM];
   logic                  cmd_err_q;
   logic                  cmd_err_d;
   logic [7:0]            err_count_q;
   logic [7:0]            err_count_d;
   logic                  unused_value;

   assign cmd          = cmd_t'(s_data);
   assign unused_value = ^cmd.value[7:PHASE_BITS];

   always_comb begin
      write_ok  = s_valid && (cmd.opcode == OP_WRITE) && (int'(cmd.addr) < N_ELEM);
      apply_ok  = s_valid && (cmd.opcode == OP_APPLY) && !ser_busy;
      clear_cmd = s_valid && (cmd.opcode == OP_CLEAR);
      reject    = s_valid && !(write_ok || apply_ok || clear_cmd);
   end

   always_comb begin
      shadow_d = shadow_q;
      for (int i = 0; i < N_ELEM; i++) begin
         if (clear_cmd) begin
            shadow_d[i] = '0;
         end else if (write_ok && (int'(cmd.addr) == i)) begin
            shadow_d[i] = cmd.value[PHASE_BITS-1:0];
         end
      end
   end

   // Element N_ELEM-1 occupies the MSBs so it leaves the chain first.
   always_comb begin
      snapshot = '0;
      for (int i = 0; i < N_ELEM; i++) begin
         snapshot[i*PHASE_BITS +: PHASE_BITS] = shadow_q[i];
      end
   end

   always_comb begin
      cmd_err_d   = reject;
      err_count_d = err_count_q;
      if (reject && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_ELEM; i++) begin
            shadow_q[i] <= '0;
         end
         cmd_err_q   <= 1'b0;
         err_count_q <= '0;
      end else begin
         shadow_q    <= shadow_d;
         cmd_err_q   <= cmd_err_d;
         err_count_q <= err_count_d;
      end
   end

   ris_serializer #(
      .NB       (NB),
      .SCLK_DIV (SCLK_DIV)
   ) u_ser (
      .clk       (clk),
      .rst       (rst),
      .start     (apply_ok),
      .snapshot  (snapshot),
      .busy      (ser_busy),
      .ris_sclk  (ris_sclk),
      .ris_sdo   (ris_sdo),
      .ris_latch (ris_latch)
   );

   assign busy      = ser_busy;
   assign cmd_err   = cmd_err_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_ris_frame_decoder.sv
// Directed and randomized checks of ris_frame_decoder against a shadow-bank reference model.
module tb_ris_frame_decoder;

   localparam int D  = 4;
   localparam int NE = 16;
   localparam int NB = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_valid = 1'b0;
   logic [23:0] s_data = '0;
   logic        ris_sclk, ris_sdo, ris_latch, busy, cmd_err;
   logic [7:0]  err_count;

   always #5 clk = ~clk;

   ris_frame_decoder dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .ris_sclk  (ris_sclk),
      .ris_sdo   (ris_sdo),
      .ris_latch (ris_latch),
      .busy      (busy),
      .cmd_err   (cmd_err),
      .err_count (err_count)
   );

   int tests  = 0;
   int failed = 0;

   int          shadow_m [NE];
   int          errs_m = 0;
   logic [31:0] exp_word;
   int          apply_cyc;
   int          sent_cyc;

   int          cyc = 0;
   int          rises, latch_cnt, busy_cnt, unstable, first_rise, latch_first;
   int          err_pulses = 0;
   logic [31:0] cap;
   logic        sclk_prev = 1'b0;
   logic        sdo_at_rise = 1'b0;

   // Observes the pins once per cycle, halfway between active edges.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (ris_sclk && !sclk_prev) begin
         if (rises == 0) first_rise <= cyc + 1;
         rises       <= rises + 1;
         cap         <= {cap[30:0], ris_sdo};
         sdo_at_rise <= ris_sdo;
      end else if (ris_sclk && (ris_sdo !== sdo_at_rise)) begin
         unstable <= unstable + 1;
      end
      if (ris_latch) begin
         if (latch_cnt == 0) latch_first <= cyc + 1;
         latch_cnt <= latch_cnt + 1;
      end
      if (busy) busy_cnt <= busy_cnt + 1;
      if (cmd_err) err_pulses <= err_pulses + 1;
      sclk_prev <= ris_sclk;
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      rises       = 0;
      latch_cnt   = 0;
      busy_cnt    = 0;
      unstable    = 0;
      cap         = '0;
      first_rise  = -1;
      latch_first = -1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] model_word();
      logic [31:0] w = '0;
      for (int i = 0; i < NE; i++) w = w | (32'(shadow_m[i]) << (2 * i));
      return w;
   endfunction

   function automatic int sat_errs();
      return (errs_m > 255) ? 255 : errs_m;
   endfunction

   task automatic send(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] val,
                       output logic err);
      s_data   = {val, addr, op};
      s_valid  = 1'b1;
      sent_cyc = cyc;
      @(negedge clk);
      #1;
      s_valid = 1'b0;
      err     = cmd_err;
   endtask

   task automatic wr(input int addr, input int val);
      logic err;
      send(8'h01, 8'(addr), 8'(val), err);
      if (addr < NE) shadow_m[addr] = val % 4;
      else errs_m++;
      check("write_err", err, (addr >= NE) ? 1 : 0);
   endtask

   task automatic bad(input logic [7:0] op);
      logic err;
      send(op, 8'($urandom), 8'($urandom), err);
      errs_m++;
      check("bad_op_err", err, 1);
   endtask

   task automatic clr();
      logic err;
      send(8'h03, 8'h00, 8'h00, err);
      for (int i = 0; i < NE; i++) shadow_m[i] = 0;
      check("clear_err", err, 0);
   endtask

   task automatic apply(input bit accept);
      logic        err;
      logic [31:0] w;
      w = model_word();
      send(8'h02, 8'h00, 8'h00, err);
      if (accept) begin
         apply_cyc = sent_cyc;
         exp_word  = w;
      end else begin
         errs_m++;
      end
      check("apply_err", err, accept ? 0 : 1);
   endtask

   task automatic check_xfer(input string tag);
      int n = 0;
      while (busy && n < 2000) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({tag, "_idle_timeout"}, busy, 0);
      check({tag, "_rises"}, rises, NB);
      check({tag, "_bits"}, cap, exp_word);
      check({tag, "_latch_len"}, latch_cnt, D);
      check({tag, "_busy_len"}, busy_cnt, 1 + 2 * D * NB + D);
      check({tag, "_first_rise"}, first_rise - apply_cyc, 2 + D);
      check({tag, "_latch_start"}, latch_first - apply_cyc, 2 + 2 * D * NB);
      check({tag, "_sdo_stable"}, unstable, 0);
      check({tag, "_err_count"}, err_count, sat_errs());
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_sclk"}, ris_sclk, 0);
      check({tag, "_sdo"}, ris_sdo, 0);
      check({tag, "_latch"}, ris_latch, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_cmd_err"}, cmd_err, 0);
      check({tag, "_err_count"}, err_count, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int target;
      int n;
      for (int i = 0; i < NE; i++) shadow_m[i] = 0;
      clear_mon();

      @(negedge clk);
      #1;
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      check_zero_outputs("reset");

      // Basic apply: expected stream 01 followed by zeros then 11
      wr(0, 3);
      wr(15, 1);
      clear_mon();
      apply(1);
      check("basic_word_const", exp_word, 32'h4000_0003);
      check_xfer("basic");

      // Randomized bank contents with occasional bad commands
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 8; k++) begin
            n = $urandom_range(0, 9);
            if (n == 0) bad(8'($urandom_range(4, 255)));
            else wr($urandom_range(0, 19), $urandom_range(0, 255));
         end
         clear_mon();
         apply(1);
         check_xfer("rand");
      end

      // Rejections while a transfer is in flight
      p0 = err_pulses;
      clear_mon();
      apply(1);
      idle(20);
      wr(16, 1);
      bad(8'h7F);
      apply(0);
      check_xfer("reject");
      check("reject_pulses", err_pulses - p0, 3);

      // Write during SHIFT leaves current stream alone, shows up next time
      clear_mon();
      apply(1);
      idle(30);
      wr(15, 2);
      check_xfer("wdt_cur");
      clear_mon();
      apply(1);
      check("wdt_elem15", exp_word[31:30], 2);
      check_xfer("wdt_next");

      // Write landing in the LOAD cycle is not part of the snapshot
      clear_mon();
      apply(1);
      wr(0, (shadow_m[0] + 1) % 4);
      check_xfer("load_write");

      // APPLY in the final LATCH cycle is rejected; the next cycle is accepted
      clear_mon();
      apply(1);
      target = apply_cyc + 1 + 2 * D * NB + D;
      n = 0;
      while (cyc < target && n < 1000) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("last_latch_cycle", cyc, target);
      check("last_latch_high", ris_latch, 1);
      apply(0);
      clear_mon();
      apply(1);
      check_xfer("after_latch");

      // CLEAR wipes the whole bank
      for (int i = 0; i < NE; i++) wr(i, 3);
      clr();
      clear_mon();
      apply(1);
      check("clear_word_const", exp_word, 0);
      check_xfer("clear");

      // Reset in the middle of SHIFT
      for (int i = 0; i < NE; i++) wr(i, $urandom_range(1, 3));
      apply(1);
      idle(40);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check_zero_outputs("mid_reset");
      for (int i = 0; i < NE; i++) shadow_m[i] = 0;
      errs_m = 0;
      clear_mon();
      apply(1);
      check_xfer("post_reset");

      // Error counter saturation
      p0 = err_pulses;
      for (int i = 0; i < 300; i++) bad(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(4, 255)));
      check("sat_pulses", err_pulses - p0, 300);
      check("sat_count", err_count, 255);
      check("sat_model", err_count, sat_errs());

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/ris_frame_decoder.md
# ris_frame_decoder

Consumes 24-bit command words from the UART receive stage and maintains a shadow bank of per-element phase settings for the reconfigurable reflective surface. On an APPLY command it snapshots the bank and serialises it to the RIS driver chain over a clock/data/latch interface. It sits directly downstream of the UART receiver, taking its `m_valid`/`m_data` outputs, and drives the board-level RIS driver pins.

## Interface
- `N_ELEM`, 16: number of RIS elements; must be ≤ 256.
- `PHASE_BITS`, 2: phase-code width per element.
- `W_IN`, 24: input word width; fixed at 3 bytes.
- `SCLK_DIV`, 4: clk cycles per half-period of `ris_sclk`; ≥ 1.

Ports:
- `clk`  in  1: single clock for the whole block.
- `rst`  in  1: synchronous, active-high reset.
- `s_valid`  in  1: one-cycle strobe marking a complete word.
- `s_data`  in  W_IN: command word. Byte 0 (first received byte) is in `[7:0]`.
- `ris_sclk`  out  1: serial clock to the driver chain.
- `ris_sdo`  out  1: serial data. Valid while `ris_sclk` is high; receiver samples on the rising edge.
- `ris_latch`  out  1: latch pulse after the last bit.
- `busy`  out  1: serialiser active.
- `cmd_err`  out  1: one-cycle pulse on a rejected command.
- `err_count`  out  8: saturating count of rejected commands.

## Operation
Word fields:
- opcode = `s_data[7:0]`
- addr = `s_data[15:8]`
- value = `s_data[23:16]`

Opcodes:
- **0x01 WRITE**: `shadow[addr] <= value[PHASE_BITS-1:0]`. Upper value bits are ignored. If addr ≥ N_ELEM the command is rejected.
- **0x02 APPLY**: accepted only if the serialiser is in IDLE; otherwise rejected. An accepted APPLY starts serialisation.
- **0x03 CLEAR**: all shadow entries are set to 0. This is allowed while busy and does not affect a transfer in flight.
- **Any other opcode**: rejected.

Every rejection pulses `cmd_err` and increments `err_count`. `err_count` saturates at 255.

No backpressure exists. WRITE and CLEAR are always accepted (when in range/valid), including while `busy`.

Serialiser FSM:
- **IDLE**: waits for an accepted APPLY, then goes to LOAD.
- **LOAD** (1 cycle): the shift register takes the snapshot `{shadow[N_ELEM-1], …, shadow[0]}`. Total bits NB = N_ELEM·PHASE_BITS. Transmission is MSB first, so element N_ELEM-1's MSB goes out first. Goes to SHIFT.
- **SHIFT**: for each bit, `ris_sdo` = current bit. `ris_sclk` is low for SCLK_DIV cycles, then high for SCLK_DIV cycles, after which the register shifts. After NB bits, goes to LATCH.
- **LATCH**: `ris_sclk` = 0, `ris_latch` = 1 for SCLK_DIV cycles, then returns to IDLE.

## Timing
- Reset values:
  - `ris_sclk`, `ris_sdo`, `ris_latch`, `busy`, `cmd_err` = 0.
  - `err_count` = 0.
  - All shadow entries = 0; FSM in IDLE.
  - Reset applies at the next clk edge with `rst` high and aborts any transfer mid-stream. Outputs are 0 in the following cycle.
- Commands are decoded combinationally from `s_data` while `s_valid` is high. All effects land on that same edge:
  - a WRITE result is visible in the shadow on the next cycle;
  - `cmd_err` is high in the cycle after `s_valid`.
- For an APPLY with `s_valid` in cycle T:
  - LOAD is in cycle T+1, and `busy` = 1 from T+1.
  - First `ris_sclk` rise is at T+2+SCLK_DIV.
  - `ris_latch` is high for cycles T+2+2·SCLK_DIV·NB … T+1+2·SCLK_DIV·NB+SCLK_DIV.
  - `busy` deasserts in the first cycle after the latch window.
- A WRITE arriving in the LOAD cycle updates the shadow, but the snapshot holds the pre-write value.
- An APPLY arriving in the last LATCH cycle is rejected, because the FSM is not yet in IDLE.
- `ris_sdo` is stable for the full high phase of `ris_sclk`.

## Structure
- Package `ris_pkg` holds:
  - opcode constants `OP_WRITE`, `OP_APPLY`, `OP_CLEAR`;
  - the serialiser state encoding (IDLE/LOAD/SHIFT/LATCH).
- Sub-module `ris_serializer` contains the FSM, the bit and divider counters, and the NB-bit shift register. It takes a `start` strobe and a parallel `snapshot`, and outputs `busy`, `ris_sclk`, `ris_sdo`, `ris_latch`.
- The top level holds the decoder, the shadow bank and the error counter.

## Test plan
- **Basic apply**: with defaults, WRITE addr 0 val 3, WRITE addr 15 val 1, then APPLY. Expect 32 rising edges on `ris_sclk` with sampled bits `01_000…000_11`, then `ris_latch` high for 4 cycles, and `busy` high for 1+256+4 = 261 cycles.
- **Rejections**: WRITE addr 16; opcode 0x7F; APPLY while busy. Expect three `cmd_err` pulses, `err_count` = 3, shadow unchanged, and the in-flight transfer unaffected.
- **Write during transfer**: WRITE addr 15 val 2 during SHIFT. Current bits are unchanged; the next APPLY outputs element 15 as `10`.
- **CLEAR**: write all elements = 3, CLEAR, APPLY. Expect all 32 sampled bits = 0.
- **Reset mid-operation**: assert `rst` mid-SHIFT. The next cycle shows all outputs 0. A subsequent APPLY transmits all zeros.
- **Saturation**: 300 bad opcodes. Expect `err_count` = 255 and 300 `cmd_err` pulses.
